// File: rtl/if_prefetch.sv
// if_prefetch: RV32I fetch front end; throttled sequential requests, in-order response FIFO,
// redirect flush that drops every response already in flight.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] pending_q, pending_d, discard_q, discard_d, count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0] mem_q [DEPTH];
  logic [63:0] mem_d [DEPTH];
  logic [CW:0] occ;
  logic req_fire, push, pop;
  always_comb begin
    target = {redirect_pc[31:2], 2'b00};
    occ = {1'b0, count_q} + {1'b0, pending_q};
    imem_req_valid = !reset && !redirect_valid && (occ < CAP);
    imem_req_addr = fetch_pc_q;
    req_fire = imem_req_valid && imem_req_ready;
    inst_valid = !reset && (count_q != '0);
    inst = inst_valid ? mem_q[rd_ptr_q][31:0] : 32'h0000_0013;
    inst_pc = inst_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
    // A response in a redirect cycle belongs to the old path and is never pushed
    push = imem_rsp_valid && !redirect_valid && (discard_q == '0);
    pop = inst_valid && inst_ready && !redirect_valid;
    pending_d = pending_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d = redirect_valid ? pending_d
              : (imem_rsp_valid && discard_q != '0) ? discard_q - CW'(1) : discard_q;
    fetch_pc_d = redirect_valid ? target : req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    wr_ptr_d = redirect_valid ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = (push && wr_ptr_q == PW'(i)) ? {rsp_pc_q, imem_rsp_data} : mem_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      pending_q  <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) assert (!(push && count_q == CW'(DEPTH)));
  end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: random memory/decode/redirect stimulus against a path-level reference model.
module tb_if_prefetch;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] addr; int due; int ep;} ment_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  logic clk = 0, reset = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0, inst, inst_pc;
  int n_cmp = 0, n_fail = 0, n_pop = 0, cyc = 0;
  int p_ready = 100, p_iready = 100, p_redir = 0, lat_lo = 1, lat_hi = 1;
  bit do_reset = 1, force_redir = 0;
  logic [31:0] force_pc = 0, next_addr = RST_PC;
  int fifo_cnt = 0, ep = 0, last_due = 0;
  ment_t memq[$];
  exp_t expq[$];
  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F17;
  endfunction
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // Memory, decode and redirect driver plus the path model: every accepted request on the
  // current path must reach decode in order; a redirect discards the whole old path.
  initial begin
    ment_t m;
    bit redir, fire, pop, exp_rv;
    int due;
    forever begin
      @(negedge clk);
      cyc++;
      reset = do_reset;
      if (do_reset) begin
        redirect_valid = 0; imem_req_ready = 0; imem_rsp_valid = 0; inst_ready = 0; force_redir = 0;
        memq.delete(); expq.delete();
        fifo_cnt = 0; next_addr = RST_PC; ep++; last_due = 0;
        #1;
        chk(!imem_req_valid, "rst_req_valid", 32'(imem_req_valid), 0);
        chk(!inst_valid, "rst_inst_valid", 32'(inst_valid), 0);
        chk(inst == NOP, "rst_inst", inst, NOP);
        chk(inst_pc == 0, "rst_inst_pc", inst_pc, 0);
      end else begin
        redir = force_redir || ($urandom_range(99) < p_redir);
        redirect_valid = redir;
        redirect_pc = force_redir ? force_pc : $urandom;
        force_redir = 0;
        imem_req_ready = $urandom_range(99) < p_ready;
        inst_ready = $urandom_range(99) < p_iready;
        imem_rsp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_data = imem_rsp_valid ? word_at(memq[0].addr) : $urandom;
        #1;
        exp_rv = !redir && (memq.size() + fifo_cnt < DEPTH);
        chk(imem_req_valid == exp_rv, "req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk(imem_req_addr == next_addr, "req_addr", imem_req_addr, next_addr);
        chk(inst_valid == (fifo_cnt > 0), "inst_valid", 32'(inst_valid), 32'(fifo_cnt > 0));
        if (fifo_cnt == 0) begin
          chk(inst == NOP, "idle_inst", inst, NOP);
          chk(inst_pc == 0, "idle_inst_pc", inst_pc, 0);
        end
        fire = exp_rv && imem_req_ready;
        pop = (fifo_cnt > 0) && inst_ready && !redir;
        if (imem_rsp_valid) begin
          m = memq.pop_front();
          if (!redir && m.ep == ep) fifo_cnt++;
        end
        if (pop) fifo_cnt--;
        if (fire) begin
          due = cyc + $urandom_range(lat_hi, lat_lo);
          if (due < last_due) due = last_due;
          last_due = due;
          memq.push_back('{next_addr, due, ep});
          expq.push_back('{next_addr, word_at(next_addr)});
          next_addr += 32'd4;
        end
        if (redir) begin
          ep++;
          fifo_cnt = 0;
          expq.delete();
          next_addr = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end
  // Monitor: every handshake with decode consumes the oldest live expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && inst_valid && inst_ready && !redirect_valid) begin
        if (expq.size() == 0) chk(0, "pop_unexpected", inst_pc, 0);
        else begin
          e = expq.pop_front();
          chk(inst_pc == e.pc, "inst_pc", inst_pc, e.pc);
          chk(inst == e.ins, "inst", inst, e.ins);
          n_pop++;
        end
      end
    end
  end
  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1;
    force_pc = pc;
    @(posedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    do_reset = 0;
    repeat (30) @(posedge clk);
    p_iready = 0;
    repeat (20) @(posedge clk);
    p_iready = 100;
    repeat (10) @(posedge clk);
    lat_lo = 3; lat_hi = 3;
    repeat (10) @(posedge clk);
    redirect_to(32'h100);
    repeat (15) @(posedge clk);
    redirect_to(32'h203);
    repeat (5) @(posedge clk);
    p_ready = 0;
    repeat (5) @(posedge clk);
    redirect_to(32'h300);
    repeat (3) @(posedge clk);
    p_ready = 100;
    repeat (10) @(posedge clk);
    redirect_to(32'h400);
    redirect_to(32'h501);
    repeat (10) @(posedge clk);
    p_ready = 70; p_iready = 70; lat_lo = 1; lat_hi = 4; p_redir = 5;
    repeat (3000) @(posedge clk);
    do_reset = 1;
    repeat (2) @(posedge clk);
    do_reset = 0; p_redir = 0; p_ready = 100; p_iready = 100; lat_lo = 1; lat_hi = 1;
    repeat (50) @(posedge clk);
    chk(n_pop > 500, "delivered_count", 32'(n_pop), 500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
